rmii_recv_byte: RTL

- Receive-side counterpart of the RMII byte transmitter: takes dibits from an RMII PHY (LAN8720A class), finds preamble/SFD, reassembles bytes LSB-first and presents them as single-cycle strobes with frame start/end markers.
- Runs on the same 50 MHz RMII reference clock as the transmit path and supports 10 and 100 Mbps.
- Sits between PHY pins and the frame parser/capture logic of the analyzer.

---
 rtl/rmii_recv_byte.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rmii_recv_byte.sv
// RMII receive path: finds preamble/SFD in the PHY dibit stream and rebuilds LSB-first bytes.
// Optional per-frame byte counter output frame_len is enabled by defining RMII_RX_LEN_EN.
module rmii_recv_byte #(
   parameter int unsigned MIN_PREAMBLE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fast_eth,
   input  logic       rm_crs_dv,
   input  logic [1:0] rm_rx_data,
   output logic [7:0] data,
   output logic       valid,
   output logic       sof,
`ifdef RMII_RX_LEN_EN
   output logic [10:0] frame_len,
`endif
   output logic       eof,
   output logic       err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PRE  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   localparam logic [4:0] MIN_PRE = 5'(MIN_PREAMBLE);

   logic [1:0] state_q, state_d;
   logic [3:0] div_q, div_d;
   logic [4:0] pre_cnt_q, pre_cnt_d;
   logic [1:0] bit_cnt_q, bit_cnt_d;
   logic [5:0] shift_q, shift_d;
   logic       first_q, first_d;
   logic       low_q, low_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       sof_q, sof_d;
   logic       eof_q, eof_d;
   logic       err_q, err_d;
`ifdef RMII_RX_LEN_EN
   logic [10:0] len_q, len_d;
`endif

   logic       tick_s;
   logic [7:0] byte_s;

   // At 10 Mbps the divider is re-phased on carrier so the sample lands mid-dibit
   assign tick_s = fast_eth | (div_q == 4'd4);
   assign byte_s = {rm_rx_data, shift_q};

   // Next-state logic: divider, framing FSM and output strobes
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      first_d   = first_q;
      low_d     = low_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      err_d     = 1'b0;
`ifdef RMII_RX_LEN_EN
      len_d     = len_q;
`endif
      if (div_q == 4'd9) begin
         div_d = 4'd0;
      end else begin
         div_d = div_q + 4'd1;
      end

      case (state_q)
         ST_IDLE: begin
            low_d = 1'b0;
            if (rm_crs_dv) begin
               state_d   = ST_PRE;
               pre_cnt_d = 5'd0;
               div_d     = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (!tick_s) begin
               state_d = ST_PRE;
            end else if (!rm_crs_dv) begin
               state_d = ST_IDLE;
            end else begin
               case (rm_rx_data)
                  2'b00: begin
                     // Leading zeros before the preamble are tolerated, not inside it
                     if (pre_cnt_q != 5'd0) begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                     end else begin
                        state_d = ST_PRE;
                     end
                  end
                  2'b01: begin
                     if (pre_cnt_q != 5'd31) begin
                        pre_cnt_d = pre_cnt_q + 5'd1;
                     end else begin
                        pre_cnt_d = pre_cnt_q;
                     end
                  end
                  2'b11: begin
                     if (pre_cnt_q >= MIN_PRE) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 2'd0;
                        first_d   = 1'b1;
                        low_d     = 1'b0;
                     end else begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                     end
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = ST_DROP;
                  end
               endcase
            end
         end
         ST_DATA: begin
            if (!tick_s) begin
               state_d = ST_DATA;
            end else if (!rm_crs_dv && low_q) begin
               // bit_cnt already includes the first low dibit; 1 means byte-aligned end
               eof_d   = 1'b1;
               err_d   = bit_cnt_q[1];
               state_d = ST_IDLE;
            end else begin
               shift_d   = byte_s[7:2];
               bit_cnt_d = bit_cnt_q + 2'd1;
               low_d     = ~rm_crs_dv;
               if (bit_cnt_q == 2'd3) begin
                  data_d  = byte_s;
                  valid_d = 1'b1;
                  sof_d   = first_q;
                  first_d = 1'b0;
`ifdef RMII_RX_LEN_EN
                  if (first_q) begin
                     len_d = 11'd1;
                  end else if (len_q != 11'd2047) begin
                     len_d = len_q + 11'd1;
                  end else begin
                     len_d = len_q;
                  end
`endif
               end else begin
                  data_d = data_q;
               end
            end
         end
         ST_DROP: begin
            if (!tick_s) begin
               state_d = ST_DROP;
            end else if (!rm_crs_dv && low_q) begin
               state_d = ST_IDLE;
            end else begin
               low_d = ~rm_crs_dv;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         div_q     <= 4'd0;
         pre_cnt_q <= 5'd0;
         bit_cnt_q <= 2'd0;
         shift_q   <= 6'd0;
         first_q   <= 1'b0;
         low_q     <= 1'b0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         err_q     <= 1'b0;
`ifdef RMII_RX_LEN_EN
         len_q     <= 11'd0;
`endif
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         pre_cnt_q <= pre_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         first_q   <= first_d;
         low_q     <= low_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         sof_q     <= sof_d;
         eof_q     <= eof_d;
         err_q     <= err_d;
`ifdef RMII_RX_LEN_EN
         len_q     <= len_d;
`endif
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign sof   = sof_q;
   assign eof   = eof_q;
   assign err   = err_q;
`ifdef RMII_RX_LEN_EN
   assign frame_len = len_q;
`endif

endmodule
